// File: rtl/clock_pkg.sv
// Shared constants and encodings for the clock time-set controller.
package clock_pkg;

  localparam int HOUR_MAX   = 23;
  localparam int MINSEC_MAX = 59;

  localparam logic [1:0] FLD_NONE = 2'd0;
  localparam logic [1:0] FLD_HOUR = 2'd1;
  localparam logic [1:0] FLD_MIN  = 2'd2;
  localparam logic [1:0] FLD_SEC  = 2'd3;

  typedef enum logic [3:0] {
    ST_RUN   = 4'd0,
    ST_ED_H  = 4'd1,
    ST_ED_M  = 4'd2,
    ST_ED_S  = 4'd3,
    ST_LD_H  = 4'd4,
    ST_GAP_H = 4'd5,
    ST_LD_M  = 4'd6,
    ST_GAP_M = 4'd7,
    ST_LD_S  = 4'd8,
    ST_GAP_S = 4'd9
  } state_t;

endpackage

// File: rtl/wrap_counter.sv
// Mod-(MAX+1) up/down counter; a load of an out-of-range value clamps to 0.
module wrap_counter #(
  parameter int WIDTH = 6,
  parameter int MAX   = 59
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ld,
  input  logic [WIDTH-1:0] ld_val,
  input  logic             inc,
  input  logic             dec,
  output logic [WIDTH-1:0] q
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  always_ff @(posedge clock) begin
    if (!reset) begin
      q <= '0;
    end else if (ld) begin
      q <= (ld_val > MAX_V) ? '0 : ld_val;
    end else if (inc && !dec) begin
      q <= (q == MAX_V) ? '0 : q + 1'b1;
    end else if (dec && !inc) begin
      q <= (q == '0) ? MAX_V : q - 1'b1;
    end
  end

endmodule

// File: rtl/clock_time_setter.sv
// Time-set controller: captures the running time, edits hour/min/sec, then
// commits them to the clock as sequenced single-cycle load strobes.
module clock_time_setter
  import clock_pkg::*;
#(
  parameter int LOAD_GAP     = 1,
  parameter int EDIT_TIMEOUT = 1000,
  parameter int TO_W         = 10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       btn_dec,
  input  logic [5:0] sec,
  input  logic [5:0] min,
  input  logic [4:0] hour,
  output logic [5:0] data1,
  output logic [5:0] data2,
  output logic [5:0] data3,
  output logic       load1,
  output logic       load2,
  output logic       load3,
  output logic       enable,
  output logic [1:0] field,
  output logic       busy
);

  localparam int GAP_W = (LOAD_GAP > 1) ? $clog2(LOAD_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((LOAD_GAP > 0) ? LOAD_GAP - 1 : 0);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'((EDIT_TIMEOUT > 0) ? EDIT_TIMEOUT - 1 : 0);

  state_t            state;
  logic [TO_W-1:0]   to_cnt;
  logic [GAP_W-1:0]  gap_cnt;
  logic [4:0]        hour_q;
  logic [5:0]        min_q;
  logic [5:0]        sec_q;
  logic              any_btn;
  logic              capture;
  logic              step_ok;

  assign any_btn = btn_mode | btn_inc | btn_dec;
  assign capture = (state == ST_RUN) && btn_mode;
  // btn_mode wins over inc/dec in the same cycle
  assign step_ok = !btn_mode;

  wrap_counter #(.WIDTH(5), .MAX(HOUR_MAX)) u_hour (
    .clock (clock),
    .reset (reset),
    .ld    (capture),
    .ld_val(hour),
    .inc   (step_ok && (state == ST_ED_H) && btn_inc),
    .dec   (step_ok && (state == ST_ED_H) && btn_dec),
    .q     (hour_q)
  );

  wrap_counter #(.WIDTH(6), .MAX(MINSEC_MAX)) u_min (
    .clock (clock),
    .reset (reset),
    .ld    (capture),
    .ld_val(min),
    .inc   (step_ok && (state == ST_ED_M) && btn_inc),
    .dec   (step_ok && (state == ST_ED_M) && btn_dec),
    .q     (min_q)
  );

  wrap_counter #(.WIDTH(6), .MAX(MINSEC_MAX)) u_sec (
    .clock (clock),
    .reset (reset),
    .ld    (capture),
    .ld_val(sec),
    .inc   (step_ok && (state == ST_ED_S) && btn_inc),
    .dec   (step_ok && (state == ST_ED_S) && btn_dec),
    .q     (sec_q)
  );

  assign data1 = sec_q;
  assign data2 = min_q;
  assign data3 = {1'b0, hour_q};

  always_ff @(posedge clock) begin
    if (!reset) begin
      state   <= ST_RUN;
      enable  <= 1'b1;
      field   <= FLD_NONE;
      busy    <= 1'b0;
      load1   <= 1'b0;
      load2   <= 1'b0;
      load3   <= 1'b0;
      to_cnt  <= '0;
      gap_cnt <= '0;
    end else begin
      load1 <= 1'b0;
      load2 <= 1'b0;
      load3 <= 1'b0;
      case (state)
        ST_RUN: begin
          if (btn_mode) begin
            state  <= ST_ED_H;
            enable <= 1'b0;
            field  <= FLD_HOUR;
            to_cnt <= '0;
          end
        end
        ST_ED_H, ST_ED_M, ST_ED_S: begin
          to_cnt <= any_btn ? '0 : to_cnt + 1'b1;
          if (btn_mode) begin
            case (state)
              ST_ED_H: begin state <= ST_ED_M; field <= FLD_MIN; end
              ST_ED_M: begin state <= ST_ED_S; field <= FLD_SEC; end
              default: begin
                state <= ST_LD_H;
                field <= FLD_NONE;
                busy  <= 1'b1;
                load3 <= 1'b1;
              end
            endcase
          end else if (!any_btn && (EDIT_TIMEOUT != 0) && (to_cnt == TO_LAST)) begin
            state  <= ST_RUN;
            field  <= FLD_NONE;
            enable <= 1'b1;
            to_cnt <= '0;
          end
        end
        // Commit: each load state is followed by LOAD_GAP idle cycles
        ST_LD_H: begin
          if (LOAD_GAP > 0) begin state <= ST_GAP_H; gap_cnt <= GAP_LAST; end
          else begin state <= ST_LD_M; load2 <= 1'b1; end
        end
        ST_GAP_H: begin
          if (gap_cnt == '0) begin state <= ST_LD_M; load2 <= 1'b1; end
          else gap_cnt <= gap_cnt - 1'b1;
        end
        ST_LD_M: begin
          if (LOAD_GAP > 0) begin state <= ST_GAP_M; gap_cnt <= GAP_LAST; end
          else begin state <= ST_LD_S; load1 <= 1'b1; end
        end
        ST_GAP_M: begin
          if (gap_cnt == '0) begin state <= ST_LD_S; load1 <= 1'b1; end
          else gap_cnt <= gap_cnt - 1'b1;
        end
        ST_LD_S: begin
          if (LOAD_GAP > 0) begin state <= ST_GAP_S; gap_cnt <= GAP_LAST; end
          else begin state <= ST_RUN; enable <= 1'b1; busy <= 1'b0; end
        end
        ST_GAP_S: begin
          if (gap_cnt == '0) begin state <= ST_RUN; enable <= 1'b1; busy <= 1'b0; end
          else gap_cnt <= gap_cnt - 1'b1;
        end
        default: begin
          state  <= ST_RUN;
          enable <= 1'b1;
          field  <= FLD_NONE;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/clock_time_setter.md
Name: clock_time_setter

Overview:
- User-facing time-set controller that drives the set/load interface of the running clock block (data1/data2/data3, load1/load2/load3, enable).
- Captures the clock's current sec/min/hour, lets the user edit hour, then min, then sec with inc/dec pulses.
- Commits the edited values as sequenced single-cycle load pulses: hour first, then min, then sec.
- Sits between the debounced button front-end and the clock counter.

Parameters:
- LOAD_GAP, 1, idle cycles inserted after each load pulse (>=0).
- EDIT_TIMEOUT, 1000, cycles without any button pulse before the edit is aborted; 0 disables the timeout.
- TO_W, 10, timeout counter width; must satisfy 2**TO_W > EDIT_TIMEOUT.

Ports:
- clock  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-low reset.
- btn_mode  input  1  single-cycle pulse, already debounced.
- btn_inc  input  1  single-cycle pulse.
- btn_dec  input  1  single-cycle pulse.
- sec  input  6  current seconds from the clock.
- min  input  6  current minutes from the clock.
- hour  input  5  current hours from the clock.
- data1  output  6  seconds value to load.
- data2  output  6  minutes value to load.
- data3  output  6  hours value to load (bit 5 always 0).
- load1  output  1  one-cycle seconds load strobe.
- load2  output  1  one-cycle minutes load strobe.
- load3  output  1  one-cycle hours load strobe.
- enable  output  1  clock run enable; 0 while editing or committing.
- field  output  2  field being edited: 0 none, 1 hour, 2 min, 3 sec.
- busy  output  1  high during the commit sequence.

Behaviour:
- Reset (reset=0 at an edge):
  - State RUN; enable=1; load1/2/3=0; data1/2/3=0; field=0; busy=0.
  - Edit registers and timeout counter cleared.
  - Reset overrides everything, including mid-commit; no further loads are issued.
- Inputs are sampled at the edge; outputs are registered, so all responses appear the following cycle.
- States: RUN, ED_H, ED_M, ED_S, LD_H, GAP_H, LD_M, GAP_M, LD_S, GAP_S.
- RUN:
  - btn_mode -> capture hour/min/sec into the edit registers, go to ED_H. Next cycle: enable=0, field=1.
  - Out-of-range captures clamp to 0 (hour >23, min/sec >59).
  - btn_inc/btn_dec ignored.
- ED_x (edit states):
  - btn_inc increments the active field and btn_dec decrements it.
  - Wrap: hour 23<->0, min/sec 59<->0.
  - inc and dec in the same cycle -> no change.
  - btn_mode has priority over inc/dec in the same cycle: the field advances and inc/dec are dropped.
  - btn_mode advances ED_H->ED_M->ED_S->LD_H.
- Edit timeout:
  - Any button pulse clears the timeout counter.
  - When the counter reaches EDIT_TIMEOUT in any ED_x state, go to RUN, enable=1, field=0, no loads.
- data1/2/3 always reflect the edit registers.
- Commit:
  - LD_H: load3=1 for one cycle.
  - GAP_H: LOAD_GAP cycles, all loads 0.
  - LD_M: load2=1, followed by GAP_M.
  - LD_S: load1=1, followed by GAP_S.
  - Then RUN with enable=1.
  - busy=1 and field=0 from LD_H through GAP_S. All buttons are ignored.
  - With LOAD_GAP=0, the GAP states are skipped.
  - At most one load strobe is high in any cycle.
- Timing with LOAD_GAP=1, btn_mode in ED_S at cycle N:
  - load3 at N+1, load2 at N+3, load1 at N+5.
  - enable=1 and busy=0 at N+7.

Decomposition:
- Package clock_pkg holds:
  - Constants HOUR_MAX=23 and MINSEC_MAX=59.
  - Field encodings FLD_NONE/HOUR/MIN/SEC.
  - The state encoding localparams.
- One sub-module, wrap_counter (params WIDTH, MAX). Ports: clock, reset, ld, ld_val, inc, dec, q.
  - Mod-(MAX+1) up/down wrapping with clamp-on-load.
  - Instantiated three times.

Test Plan:
- Reset=0 for 2 cycles, then 1 -> enable=1, field=0, all loads 0, data=0; no activity for 50 cycles.
- Clock at 05:29:03, btn_mode -> next cycle enable=0, field=1, data3=5, data2=29, data1=3.
- In ED_H, hour=23, btn_inc -> data3=0. In ED_M, min=0, btn_dec -> data2=59. inc+dec together -> unchanged.
- Edit to 12:34:56 and commit with LOAD_GAP=1 -> load3 with data3=12 at N+1, load2 with data2=34 at N+3, load1 with data1=56 at N+5, enable=1 at N+7; each strobe exactly 1 cycle wide.
- EDIT_TIMEOUT=20: enter ED_M, no buttons for 20 cycles -> return to RUN, enable=1, field=0, zero load strobes. A btn_inc at cycle 15 restarts the count.
- Assert reset=0 in the cycle after load3 -> no load2/load1 ever; enable=1. Also: captured hour=27 clamps to data3=0.
